alu_execute_unit: RTL and testbench
===================================

// Module: alu_execute_unit
// PURPOSE
//  Execute-stage ALU downstream of ALUControl. Consumes the 4-bit alu_function code and
//  two XLEN operands through a valid/ready handshake, and returns a registered result and
//  zero flag to the branch and writeback logic. ADD/SUB/AND/OR complete in one cycle.
//  SLL/SRL/SRA run on an iterative shifter, so the operation can take several cycles.
// PARAMETERS
//  XLEN        32  operand/result width
//  SHIFT_STEP  1   bit positions shifted per iterative cycle; power of 2, <= XLEN
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     operation request valid
//  in_ready      out  1     unit can accept a request this cycle
//  alu_function  in   4     ALU_* code from parameters.vh (ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL, ALU_SRA)
//  operand_a     in   XLEN  first operand / value to shift
//  operand_b     in   XLEN  second operand; shift amount = operand_b[$clog2(XLEN)-1:0]
//  out_valid     out  1     result valid
//  out_ready     in   1     consumer accepts result
//  result        out  XLEN  operation result
//  zero          out  1     result == 0 (BEQ decision)
//  illegal_op    out  1     the accepted code was not a listed ALU_* value
// BEHAVIOUR
//  Reset (async): state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, in_ready=0 while rst high.
//  States: IDLE -> (accept a shift with shamt>0) SHIFT -> DONE; IDLE -> (accept any other op) DONE.
//   DONE -> (out_ready) IDLE. If a DONE->IDLE transition and a new accept occur in the same
//   cycle, the state moves directly to DONE or SHIFT for the new request.
//  Accept: the handshake fires on in_valid & in_ready.
//   in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back single-cycle ops
//   reach 1 op/cycle. Operands and the function code are captured on accept; later input
//   changes are ignored.
//  ADD/SUB: modulo 2^XLEN wrap, no overflow flag. AND/OR: bitwise.
//   All four present out_valid the cycle after accept (latency 1).
//  Shifts: shamt is masked to $clog2(XLEN) bits.
//   shamt==0 -> result=operand_a, latency 1.
//   Otherwise, each SHIFT cycle shifts by min(SHIFT_STEP, remaining).
//   SLL/SRL fill with 0. SRA fills with the captured operand_a[XLEN-1].
//   Latency = 1 + ceil(shamt/SHIFT_STEP) cycles from accept to out_valid.
//  Unknown code (including X/Z): result=0, zero=1, illegal_op=1, latency 1. Never hangs.
//  Output hold: while out_valid & !out_ready, result/zero/illegal_op are held stable.
//  out_valid falls the cycle after the handshake unless a new op completes in that same cycle.
//  zero and illegal_op are registered together with result and are meaningful only when out_valid=1.
//  in_ready=0 throughout SHIFT; in_valid asserted during SHIFT is not accepted and is
//   the producer's responsibility to hold.
//  Reset mid-operation (SHIFT or DONE): abort immediately. Outputs return to reset values
//   and the pending op is discarded, never delivered.
// TESTING
//  1 ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid=1, result=0, zero=1.
//  2 SUB 5-7, then AND 0xF0F0_F0F0 & 0xFF00_FF00 on back-to-back cycles
//    -> 0xFFFF_FFFE, then 0xF000_F000, one per cycle.
//  3 SRA 0x8000_0000 by 4 (SHIFT_STEP=1) -> out_valid 5 cycles after accept,
//    result 0xF800_0000; in_ready=0 during SHIFT.
//  4 SLL 0x1 by operand_b=0x0000_0021 (masked to 1) -> result 0x2.
//    SRL 0x1234 by 0 -> 0x1234, latency 1.
//  5 Backpressure: out_ready=0 for 3 cycles after completion -> result stable, in_ready=0;
//    out_ready=1 -> handshake. An op offered in that cycle is accepted.
//  6 Illegal code 4'b1111 -> illegal_op=1, result=0. Assert rst during an SRL by 31
//    -> out_valid=0 immediately; no result after release.

Source files
------------

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: execute-stage ALU with a valid/ready request side and a
// registered result side.
// ADD/SUB/AND/OR finish in one cycle. SLL/SRL/SRA use an iterative shifter
// that moves SHIFT_STEP bits per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake
//   alu_function        4-bit ALU code
//   operand_a/b         operands, shift amount = operand_b[$clog2(XLEN)-1:0]
//   out_valid/out_ready result handshake
//   result, zero        registered result and result==0 flag
//   illegal_op          accepted code was not a known ALU code
module alu_execute_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_function,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] ALU_AND      = 4'b0000;
    localparam logic [3:0] ALU_OR       = 4'b0001;
    localparam logic [3:0] ALU_ADD      = 4'b0010;
    localparam logic [3:0] ALU_SLL      = 4'b0011;
    localparam logic [3:0] ALU_SRL      = 4'b0100;
    localparam logic [3:0] ALU_SRA      = 4'b0101;
    localparam logic [3:0] ALU_SUBTRACT = 4'b0110;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam logic [SW:0] STEP = (SW + 1)'(SHIFT_STEP);

    logic [1:0]      state_q, state_d;
    logic [3:0]      func_q, func_d;
    logic [XLEN-1:0] sval_q, sval_d;
    logic [SW-1:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [SW-1:0]   shamt_in;
    logic [XLEN-1:0] alu_res;
    logic            legal;
    logic            is_shift;
    logic [SW:0]     rem_ext;
    logic [SW:0]     step;
    logic [SW-1:0]   rem_next;
    logic [XLEN-1:0] shifted;

    // in_ready is forced low during reset even though state is IDLE.
    assign in_ready = !rst && ((state_q == S_IDLE) ||
                               ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign shamt_in = operand_b[SW-1:0];

    assign out_valid  = (state_q == S_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

    // Decode of the incoming request. X/Z codes match no item and
    // fall into the illegal default.
    always_comb begin
        alu_res  = '0;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (alu_function)
            ALU_ADD:      alu_res = operand_a + operand_b;
            ALU_SUBTRACT: alu_res = operand_a - operand_b;
            ALU_AND:      alu_res = operand_a & operand_b;
            ALU_OR:       alu_res = operand_a | operand_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                is_shift = 1'b1;
                alu_res  = operand_a;
            end
            default: begin
                legal   = 1'b0;
                alu_res = '0;
            end
        endcase
    end

    // One iteration of the shifter: min(SHIFT_STEP, remaining) bits.
    always_comb begin
        rem_ext  = {1'b0, rem_q};
        step     = (rem_ext < STEP) ? rem_ext : STEP;
        rem_next = rem_q - step[SW-1:0];
        case (func_q)
            ALU_SLL: shifted = sval_q << step;
            ALU_SRL: shifted = sval_q >> step;
            // The MSB of the working value is always the captured sign.
            default: shifted = XLEN'($signed(sval_q) >>> step);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        sval_d    = sval_q;
        rem_d     = rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                sval_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d   = S_DONE;
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new accept overrides the DONE->IDLE step above.
        if (accept) begin
            func_d = alu_function;
            if (is_shift && (shamt_in != '0)) begin
                state_d = S_SHIFT;
                sval_d  = operand_a;
                rem_d   = shamt_in;
            end else begin
                state_d   = S_DONE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = !legal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            func_q    <= '0;
            sval_q    <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            sval_q    <= sval_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: table vectors, hand sequences for the multi-cycle
// corners, and random ops checked against an arithmetic reference model.
module tb_alu_execute_unit;

    localparam int XLEN = 32;
    localparam int STEP = 1;

    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SLL = 4'b0011;
    localparam logic [3:0] F_SRL = 4'b0100;
    localparam logic [3:0] F_SRA = 4'b0101;
    localparam logic [3:0] F_SUB = 4'b0110;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_function;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal_op;

    int errors = 0;
    int checks = 0;

    alu_execute_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_function(alu_function),
        .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] f);
        return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLL, F_SRL, F_SRA};
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            F_ADD: return a + b;
            F_SUB: return a - b;
            F_AND: return a & b;
            F_OR:  return a | b;
            F_SLL: return a << sh;
            F_SRL: return a >> sh;
            F_SRA: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] f,
                                   input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if ((f == F_SLL || f == F_SRL || f == F_SRA) && sh != 0)
            return 1 + (sh + STEP - 1) / STEP;
        return 1;
    endfunction

    // Issue one op, wait for its result, hold out_ready low for `hold`
    // cycles (checking stability), then complete the handshake.
    task automatic run_op(input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output logic [31:0] res, output logic z,
                          output logic ill, output int lat,
                          output int rdy_seen);
        int guard;
        out_ready    = (hold == 0);
        in_valid     = 1'b1;
        alu_function = f;
        operand_a    = a;
        operand_b    = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        alu_function = 4'($urandom);
        lat = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("result_timeout", 32'(lat), 32'd0);
        res = result;
        z   = zero;
        ill = illegal_op;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, res);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t        vecs[12];
    logic [31:0] r;
    logic        z, il;
    int          lat, rdy;
    int          vcount;

    initial begin
        vecs[0]  = '{F_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1};
        vecs[1]  = '{F_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        vecs[2]  = '{F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000,
                     1'b0, 1'b0, 1};
        vecs[3]  = '{F_OR, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1};
        vecs[4]  = '{F_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000,
                     1'b0, 1'b0, 5};
        vecs[5]  = '{F_SLL, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 2};
        vecs[6]  = '{F_SRL, 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0, 1};
        vecs[7]  = '{F_SRL, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, 32};
        vecs[8]  = '{F_SLL, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000,
                     1'b0, 1'b0, 32};
        vecs[9]  = '{F_SRA, 32'h7FFF_FFFF, 32'd30, 32'h1, 1'b0, 1'b0, 31};
        vecs[10] = '{4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 1};
        vecs[11] = '{F_SUB, 32'd3, 32'd3, 32'h0, 1'b1, 1'b0, 1};
        vcount = 12;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        alu_function = 4'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < vcount; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, r, z, il, lat, rdy);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
            check($sformatf("vec%0d_illegal", i), {31'd0, il},
                  {31'd0, vecs[i].ill});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat > 1)
                check($sformatf("vec%0d_ready_in_shift", i), 32'(rdy), 32'd0);
        end

        // Back-to-back single-cycle ops: SUB then AND, one per cycle.
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_function = F_SUB;
        operand_a = 32'd5;
        operand_b = 32'd7;
        @(posedge clk); #1;
        alu_function = F_AND;
        operand_a = 32'hF0F0_F0F0;
        operand_b = 32'hFF00_FF00;
        check("b2b_valid1", {31'd0, out_valid}, 32'd1);
        check("b2b_result1", result, 32'hFFFF_FFFE);
        check("b2b_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid2", {31'd0, out_valid}, 32'd1);
        check("b2b_result2", result, 32'hF000_F000);
        @(posedge clk); #1;
        check("b2b_valid_fall", {31'd0, out_valid}, 32'd0);

        // Backpressure, then a new op accepted in the handshake cycle.
        out_ready = 1'b0;
        in_valid = 1'b1;
        alu_function = F_ADD;
        operand_a = 32'd10;
        operand_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_result", result, 32'd30);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, 32'd30);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_function = F_OR;
        operand_a = 32'h0F;
        operand_b = 32'h30;
        @(negedge clk);
        check("bp_ready_on_hs", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", result, 32'h3F);
        @(posedge clk); #1;
        check("bp_next_fall", {31'd0, out_valid}, 32'd0);

        // Reset during a long SRL: aborted, never delivered.
        in_valid = 1'b1;
        alu_function = F_SRL;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("abort_no_result", 32'(lat), 32'd0);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  f;
            logic [31:0] a, b;
            int          hold;
            int          pick;
            pick = $urandom_range(0, 8);
            case (pick)
                0: f = F_ADD;
                1: f = F_SUB;
                2: f = F_AND;
                3: f = F_OR;
                4: f = F_SLL;
                5: f = F_SRL;
                6: f = F_SRA;
                7: f = 4'b1111;
                default: f = 4'($urandom_range(7, 15));
            endcase
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
            hold = $urandom_range(0, 2);
            run_op(f, a, b, hold, r, z, il, lat, rdy);
            check($sformatf("rnd%0d_result", i), r, ref_res(f, a, b));
            check($sformatf("rnd%0d_zero", i), {31'd0, z},
                  {31'd0, ref_res(f, a, b) == 32'd0});
            check($sformatf("rnd%0d_illegal", i), {31'd0, il},
                  {31'd0, !ref_legal(f)});
            check($sformatf("rnd%0d_latency", i), 32'(lat),
                  32'(ref_lat(f, b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
